adder_32bit: RTL and testbench



---
 rtl/adder_32bit.sv | 108 ++++++++++
 tb/tb_adder_32bit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/adder_32bit.sv
// Registered 32-bit adder with carry-in and carry-out.
// The sum is formed by eight 4-bit carry-lookahead groups and a second-level
// lookahead unit that supplies the carry into every group directly from cin.
// The 33-bit result is captured every cycle.
module adder_32bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] bit_g;
    logic [31:0] bit_p;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_c;
    logic [31:0] bit_c;

    logic [31:0] sum_d;
    logic [31:0] sum_q;
    logic        cout_d;
    logic        cout_q;

    // Per-bit generate and propagate.
    always_comb begin
        bit_g = a & b;
        bit_p = a ^ b;
    end

    // Group generate/propagate for each 4-bit slice.
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            grp_g[i] = bit_g[4*i+3]
                     | (bit_p[4*i+3] & bit_g[4*i+2])
                     | (bit_p[4*i+3] & bit_p[4*i+2] & bit_g[4*i+1])
                     | (bit_p[4*i+3] & bit_p[4*i+2] & bit_p[4*i+1] & bit_g[4*i]);
            grp_p[i] = &bit_p[4*i +: 4];
        end
    end

    // Second-level lookahead: each group carry is a flat sum of products over
    // all lower group G/P terms and cin, so no carry ripples between groups.
    always_comb begin
        logic term;
        logic acc;
        term  = 1'b0;
        acc   = 1'b0;
        grp_c = '0;
        grp_c[0] = cin;
        for (int unsigned i = 0; i < 8; i++) begin
            acc = cin;
            for (int unsigned k = 0; k <= i; k++) begin
                acc = acc & grp_p[k];
            end
            for (int unsigned j = 0; j <= i; j++) begin
                term = grp_g[j];
                for (int unsigned k = j + 1; k <= i; k++) begin
                    term = term & grp_p[k];
                end
                acc = acc | term;
            end
            grp_c[i+1] = acc;
        end
    end

    // Bit carries inside each group, expanded from the group carry-in.
    always_comb begin
        bit_c = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            bit_c[4*i]   = grp_c[i];
            bit_c[4*i+1] = bit_g[4*i]
                         | (bit_p[4*i] & grp_c[i]);
            bit_c[4*i+2] = bit_g[4*i+1]
                         | (bit_p[4*i+1] & bit_g[4*i])
                         | (bit_p[4*i+1] & bit_p[4*i] & grp_c[i]);
            bit_c[4*i+3] = bit_g[4*i+2]
                         | (bit_p[4*i+2] & bit_g[4*i+1])
                         | (bit_p[4*i+2] & bit_p[4*i+1] & bit_g[4*i])
                         | (bit_p[4*i+2] & bit_p[4*i+1] & bit_p[4*i] & grp_c[i]);
        end
    end

    // Next-state result: sum bits and carry out of bit 31.
    always_comb begin
        sum_d  = bit_p ^ bit_c;
        cout_d = grp_c[8];
    end

    // Output registers; reset clears them immediately and wins over the clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_adder_32bit.sv
// Self-checking bench for adder_32bit: directed vector table, random vectors,
// reset behaviour and a short mid-stream reset pulse, via an expected-value queue.
module tb_adder_32bit;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [32:0] exp;
    } vec_t;

    vec_t        tbl [12];
    logic [32:0] exp_q [$];
    logic [32:0] last_exp;
    int          checks;
    int          errors;

    adder_32bit u_dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs (away from the edge) and queue the reference result.
    task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic vc);
        a   = va;
        b   = vb;
        cin = vc;
        exp_q.push_back({1'b0, va} + {1'b0, vb} + {32'b0, vc});
    endtask

    // Advance one edge, then pop and compare the oldest expectation.
    task automatic step(input string name);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %h expected none", name, {cout, sum});
        end else begin
            last_exp = exp_q.pop_front();
            check(name, {cout, sum}, last_exp);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        last_exp = '0;

        tbl[0]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000};
        tbl[1]  = '{32'hFFC0_0FFC, 32'hFFFF_F003, 1'b0, 33'h1_FFBF_FFFF};
        tbl[2]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000};
        tbl[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000};
        tbl[4]  = '{32'h0000_000F, 32'h0000_0001, 1'b0, 33'h0_0000_0010};
        tbl[5]  = '{32'h0FFF_FFFF, 32'h0000_0000, 1'b1, 33'h0_1000_0000};
        tbl[6]  = '{32'h1234_5678, 32'h8765_4321, 1'b0, 33'h0_9999_9999};
        tbl[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF};
        tbl[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000};
        tbl[9]  = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 33'h0_0001_FFFF};
        tbl[10] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0_0000_0001};
        tbl[11] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 33'h0_0100_0100};

        // Reset held with active inputs: outputs stay zero across edges.
        rst = 1'b1;
        a   = 32'hFFFF_FFFF;
        b   = 32'h0000_0001;
        cin = 1'b1;
        #2;
        check("reset_async", {cout, sum}, 33'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", {cout, sum}, 33'h0);
        end
        rst = 1'b0;
        exp_q.push_back(33'h1_0000_0001);
        step("reset_release");

        // Directed table; also confirm outputs hold until the capturing edge.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].cin);
            #2;
            check("hold_before_edge", {cout, sum}, last_exp);
            step("table_vec");
            check("table_const", {cout, sum}, tbl[i].exp);
        end

        // Random vectors, with a sub-period reset pulse inserted mid-stream.
        for (int i = 0; i < 10000; i++) begin
            drive($urandom, $urandom, 1'($urandom_range(0, 1)));
            if (i == 5000) begin
                #2;
                rst = 1'b1;
                #1;
                check("midrun_reset_async", {cout, sum}, 33'h0);
                #1;
                rst = 1'b0;
                #1;
                check("midrun_reset_held", {cout, sum}, 33'h0);
            end
            step("random_vec");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
